layer_sequencer: RTL and testbench

Sequences the convolution/fully-connected accumulate-activate datapath through a small programmable list of layers. For each layer it drives the layer configuration: ofmap size and input channel count for conv, node counts and the start pulse for FC. It then waits until every participating lane has reported its last activation before moving on. It sits between the host/config bus and the accumulate-activate datapath, and tells the upstream feeder when each layer may begin.

---
 rtl/layer_sequencer.sv | 173 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a small layer table, drives per-layer conv/FC config
// to the accumulate-activate datapath and waits for every participating lane's last activation.
module layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_wren_i,
  input  logic [LAYER_W-1:0] cfg_addr_i,
  input  logic [14:0]        cfg_data_i,
  input  logic [LAYER_W:0]   num_layers_i,
  input  logic [15:0]        lane_mask_i,
  input  logic               start_i,
  input  logic [16:0]        act_last_i,
  output logic [4:0]         ofmap_size_o,
  output logic [5:0]         ifmap_ch_o,
  output logic [6:0]         in_node_num_o,
  output logic [6:0]         out_node_num_o,
  output logic               start_fc_o,
  output logic               layer_start_o,
  output logic [LAYER_W-1:0] cur_layer_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN_CONV, S_RUN_FC, S_NEXT, S_DONE
  } state_e;

  localparam logic [LAYER_W:0]   ONE_EXT = (LAYER_W + 1)'(1);
  localparam logic [LAYER_W-1:0] ONE_IDX = LAYER_W'(1);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] idx_q, idx_d;
  logic [LAYER_W:0]   num_q, num_d;
  logic [15:0]        mask_q, mask_d;
  logic [15:0]        flags_q, flags_d;
  logic               is_fc_q, is_fc_d;
  logic [14:0]        table_q [NUM_LAYERS];
  logic [14:0]        table_d [NUM_LAYERS];
  logic [4:0]         ofmap_size_q, ofmap_size_d;
  logic [5:0]         ifmap_ch_q, ifmap_ch_d;
  logic [6:0]         in_node_q, in_node_d;
  logic [6:0]         out_node_q, out_node_d;
  logic               start_fc_q, start_fc_d;
  logic               layer_start_q, layer_start_d;
  logic [LAYER_W-1:0] cur_layer_q, cur_layer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [14:0]        entry;
  logic [15:0]        conv_hits;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    num_d         = num_q;
    mask_d        = mask_q;
    flags_d       = flags_q;
    is_fc_d       = is_fc_q;
    table_d       = table_q;
    ofmap_size_d  = ofmap_size_q;
    ifmap_ch_d    = ifmap_ch_q;
    in_node_d     = in_node_q;
    out_node_d    = out_node_q;
    start_fc_d    = 1'b0;
    layer_start_d = 1'b0;
    entry         = table_q[idx_q];
    conv_hits     = act_last_i[15:0] & mask_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_wren_i) table_d[cfg_addr_i] = cfg_data_i;
        if (start_i) begin
          num_d   = num_layers_i;
          mask_d  = lane_mask_i;
          idx_d   = '0;
          state_d = (num_layers_i == '0) ? S_DONE : S_LOAD;
        end
      end
      // Config fields of the other layer type keep their last values.
      S_LOAD: begin
        is_fc_d = entry[14];
        if (entry[14]) begin
          in_node_d  = entry[13:7];
          out_node_d = entry[6:0];
        end else begin
          ofmap_size_d = entry[11:7];
          ifmap_ch_d   = entry[5:0];
        end
        layer_start_d = 1'b1;
        start_fc_d    = entry[14];
        state_d       = S_ARM;
      end
      S_ARM: begin
        flags_d = '0;
        state_d = is_fc_q ? S_RUN_FC : S_RUN_CONV;
      end
      // The final lane's pulse completes the layer in the same cycle it arrives.
      S_RUN_CONV: begin
        flags_d = flags_q | conv_hits;
        if ((flags_q | conv_hits) == mask_q) state_d = S_NEXT;
      end
      S_RUN_FC: begin
        if (act_last_i[16]) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (({1'b0, idx_q} + ONE_EXT) == num_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ONE_IDX;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cur_layer_d = idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      num_q         <= '0;
      mask_q        <= '0;
      flags_q       <= '0;
      is_fc_q       <= 1'b0;
      ofmap_size_q  <= '0;
      ifmap_ch_q    <= '0;
      in_node_q     <= '0;
      out_node_q    <= '0;
      start_fc_q    <= 1'b0;
      layer_start_q <= 1'b0;
      cur_layer_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) table_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      mask_q        <= mask_d;
      flags_q       <= flags_d;
      is_fc_q       <= is_fc_d;
      ofmap_size_q  <= ofmap_size_d;
      ifmap_ch_q    <= ifmap_ch_d;
      in_node_q     <= in_node_d;
      out_node_q    <= out_node_d;
      start_fc_q    <= start_fc_d;
      layer_start_q <= layer_start_d;
      cur_layer_q   <= cur_layer_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      for (int i = 0; i < NUM_LAYERS; i++) table_q[i] <= table_d[i];
    end
  end

  assign ofmap_size_o   = ofmap_size_q;
  assign ifmap_ch_o     = ifmap_ch_q;
  assign in_node_num_o  = in_node_q;
  assign out_node_num_o = out_node_q;
  assign start_fc_o     = start_fc_q;
  assign layer_start_o  = layer_start_q;
  assign cur_layer_o    = cur_layer_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: builds an expected per-cycle timeline from the layer
// table, lane mask and act_last schedule, then drives the DUT and compares every cycle.
module tb_layer_sequencer;

  localparam int MAXC = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wren_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [14:0] cfg_data_i = '0;
  logic [2:0]  num_layers_i = '0;
  logic [15:0] lane_mask_i = '0;
  logic        start_i = 1'b0;
  logic [16:0] act_last_i = '0;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [6:0]  in_node_num_o;
  logic [6:0]  out_node_num_o;
  logic        start_fc_o;
  logic        layer_start_o;
  logic [1:0]  cur_layer_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [14:0] tbl_m [4];
  logic [4:0]  m_of;
  logic [5:0]  m_ic;
  logic [6:0]  m_in, m_on;
  int          off_a [4][17];
  int          rep_a [4][17];

  // Expected timeline, indexed by cycle relative to the accepted start
  logic [16:0] sched  [MAXC];
  logic        e_ls   [MAXC];
  logic        e_sfc  [MAXC];
  logic        e_done [MAXC];
  logic        e_busy [MAXC];
  logic [4:0]  e_of   [MAXC];
  logic [5:0]  e_ic   [MAXC];
  logic [6:0]  e_in   [MAXC];
  logic [6:0]  e_on   [MAXC];
  int          e_cl   [MAXC];

  layer_sequencer #(.NUM_LAYERS(4), .LAYER_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wren_i     (cfg_wren_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_data_i     (cfg_data_i),
    .num_layers_i   (num_layers_i),
    .lane_mask_i    (lane_mask_i),
    .start_i        (start_i),
    .act_last_i     (act_last_i),
    .ofmap_size_o   (ofmap_size_o),
    .ifmap_ch_o     (ifmap_ch_o),
    .in_node_num_o  (in_node_num_o),
    .out_node_num_o (out_node_num_o),
    .start_fc_o     (start_fc_o),
    .layer_start_o  (layer_start_o),
    .cur_layer_o    (cur_layer_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_of"},   32'(ofmap_size_o), 0);
    check({tag, "_ic"},   32'(ifmap_ch_o), 0);
    check({tag, "_in"},   32'(in_node_num_o), 0);
    check({tag, "_on"},   32'(out_node_num_o), 0);
    check({tag, "_sfc"},  32'(start_fc_o), 0);
    check({tag, "_ls"},   32'(layer_start_o), 0);
    check({tag, "_cl"},   32'(cur_layer_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) tbl_m[i] = '0;
    m_of = '0; m_ic = '0; m_in = '0; m_on = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 1'b0; cfg_wren_i = 1'b0; act_last_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [14:0] d);
    cfg_wren_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    @(posedge clk);
    #1;
    cfg_wren_i = 1'b0;
    tbl_m[a] = d;
    check("idle_busy", 32'(busy_o), 0);
  endtask

  task automatic clear_offsets(input int v);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 17; k++) begin
        off_a[i][k] = v;
        rep_a[i][k] = -1;
      end
  endtask

  task automatic gen_offsets(input logic [15:0] mask);
    int mx;
    for (int i = 0; i < 4; i++) begin
      mx = 0;
      for (int k = 0; k < 17; k++) begin
        off_a[i][k] = $urandom_range(0, 7);
        rep_a[i][k] = -1;
        if (k < 16 && mask[k] && off_a[i][k] > mx) mx = off_a[i][k];
      end
      for (int k = 0; k < 16; k++)
        if (mask[k] && off_a[i][k] < mx && $urandom_range(0, 2) == 0)
          rep_a[i][k] = off_a[i][k] + $urandom_range(1, mx - off_a[i][k]);
    end
  endtask

  // One run: start accepted in cycle 0; abort_at >= 0 pulls reset during that cycle.
  task automatic run_prog(input int nl, input logic [15:0] mask, input int abort_at,
                          input bit same_wr, input logic [1:0] wa, input logic [14:0] wd);
    int arm_c [4];
    int run_c [4];
    int end_c [4];
    int t, mx, done_c, len;
    logic [16:0] allow;
    if (same_wr) tbl_m[wa] = wd;

    t = 2;
    for (int i = 0; i < nl; i++) begin
      arm_c[i] = t;
      run_c[i] = t + 1;
      if (tbl_m[i][14]) begin
        end_c[i] = run_c[i] + off_a[i][16];
      end else begin
        mx = 0;
        for (int k = 0; k < 16; k++) if (mask[k] && off_a[i][k] > mx) mx = off_a[i][k];
        end_c[i] = run_c[i] + mx;
      end
      t = end_c[i] + 3;
    end
    done_c = (nl == 0) ? 1 : end_c[nl-1] + 2;
    len = done_c + 3;

    for (int c = 0; c <= len; c++) begin
      e_ls[c] = 1'b0; e_sfc[c] = 1'b0; e_cl[c] = -1;
      e_busy[c] = (c >= 1 && c <= done_c);
      e_done[c] = (c == done_c);
      allow = 17'h1FFFF;
      for (int i = 0; i < nl; i++) begin
        if (c == arm_c[i]) begin
          e_ls[c] = 1'b1;
          e_sfc[c] = tbl_m[i][14];
          if (tbl_m[i][14]) begin
            m_in = tbl_m[i][13:7]; m_on = tbl_m[i][6:0];
          end else begin
            m_of = tbl_m[i][11:7]; m_ic = tbl_m[i][5:0];
          end
        end
        if (c >= arm_c[i] && c <= end_c[i]) e_cl[c] = i;
        if (c >= run_c[i] && c <= end_c[i])
          allow = tbl_m[i][14] ? {1'b0, 16'hFFFF} : {1'b1, ~mask};
      end
      e_of[c] = m_of; e_ic[c] = m_ic; e_in[c] = m_in; e_on[c] = m_on;
      sched[c] = 17'($urandom & $urandom) & allow;
    end
    for (int i = 0; i < nl; i++) begin
      if (tbl_m[i][14]) begin
        sched[run_c[i] + off_a[i][16]][16] = 1'b1;
      end else begin
        for (int k = 0; k < 16; k++)
          if (mask[k]) begin
            sched[run_c[i] + off_a[i][k]][k] = 1'b1;
            if (rep_a[i][k] >= 0) sched[run_c[i] + rep_a[i][k]][k] = 1'b1;
          end
      end
    end

    for (int c = 0; c < len; c++) begin
      if (c == 0) begin
        start_i = 1'b1; num_layers_i = 3'(nl); lane_mask_i = mask;
        cfg_wren_i = same_wr; cfg_addr_i = wa; cfg_data_i = wd;
      end else if (c <= done_c) begin
        start_i      = ($urandom_range(0, 3) == 0);
        cfg_wren_i   = ($urandom_range(0, 3) == 0);
        cfg_addr_i   = 2'($urandom);
        cfg_data_i   = 15'($urandom);
        num_layers_i = 3'($urandom_range(0, 4));
        lane_mask_i  = 16'($urandom);
      end else begin
        start_i = 1'b0; cfg_wren_i = 1'b0;
      end
      act_last_i = sched[c];
      if (c == abort_at) rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        check_zero("abort");
        rst_n = 1'b1; start_i = 1'b0; cfg_wren_i = 1'b0;
        model_reset();
        for (int j = 0; j < 4; j++) begin
          act_last_i = 17'($urandom);
          @(posedge clk);
          #1;
          check("abort_done", 32'(done_o), 0);
          check("abort_busy", 32'(busy_o), 0);
          check("abort_ls",   32'(layer_start_o), 0);
        end
        act_last_i = '0;
        return;
      end
      check($sformatf("ls@%0d", c+1),   32'(layer_start_o),  32'(e_ls[c+1]));
      check($sformatf("sfc@%0d", c+1),  32'(start_fc_o),     32'(e_sfc[c+1]));
      check($sformatf("done@%0d", c+1), 32'(done_o),         32'(e_done[c+1]));
      check($sformatf("busy@%0d", c+1), 32'(busy_o),         32'(e_busy[c+1]));
      check($sformatf("of@%0d", c+1),   32'(ofmap_size_o),   32'(e_of[c+1]));
      check($sformatf("ic@%0d", c+1),   32'(ifmap_ch_o),     32'(e_ic[c+1]));
      check($sformatf("in@%0d", c+1),   32'(in_node_num_o),  32'(e_in[c+1]));
      check($sformatf("on@%0d", c+1),   32'(out_node_num_o), 32'(e_on[c+1]));
      if (e_cl[c+1] >= 0)
        check($sformatf("cl@%0d", c+1), 32'(cur_layer_o), 32'(e_cl[c+1]));
    end
    start_i = 1'b0; cfg_wren_i = 1'b0; act_last_i = '0;
  endtask

  initial begin
    logic [15:0] m;
    model_reset();
    do_reset();

    // Single conv layer: lanes 0-14 last at cycle 20, lane 15 at cycle 25, done at 27
    write_cfg(2'd0, {1'b0, 2'b00, 5'd12, 1'b0, 6'd6});
    clear_offsets(17);
    off_a[0][15] = 22;
    run_prog(1, 16'hFFFF, -1, 1'b0, 2'd0, '0);

    // Conv then FC 100 -> 10
    write_cfg(2'd1, {1'b1, 7'd100, 7'd10});
    gen_offsets(16'hFFFF);
    run_prog(2, 16'hFFFF, -1, 1'b0, 2'd0, '0);

    // Masked lanes, stray bit 16 during conv
    gen_offsets(16'h00FF);
    run_prog(1, 16'h00FF, -1, 1'b0, 2'd0, '0);

    // Staggered distinct lanes, lane 3 pulses twice
    clear_offsets(0);
    for (int k = 0; k < 16; k++) off_a[0][k] = (k * 7) % 16;
    rep_a[0][3] = off_a[0][3] + 4;
    run_prog(1, 16'hFFFF, -1, 1'b0, 2'd0, '0);

    // Empty program
    run_prog(0, 16'hFFFF, -1, 1'b0, 2'd0, '0);

    // Randomized programs; busy-time writes/starts must leave the table intact
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 4; a++)
        if ($urandom_range(0, 1) == 1) write_cfg(2'(a), 15'($urandom));
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      gen_offsets(m);
      run_prog($urandom_range(0, 4), m, -1, ($urandom_range(0, 1) == 1),
               2'($urandom), 15'($urandom));
    end

    // Reset mid-run, then a clean run on a rewritten table
    write_cfg(2'd0, {1'b0, 2'b00, 5'd7, 1'b0, 6'd33});
    clear_offsets(10);
    run_prog(1, 16'hFFFF, 6, 1'b0, 2'd0, '0);
    write_cfg(2'd0, {1'b1, 7'd55, 7'd21});
    write_cfg(2'd1, {1'b0, 2'b00, 5'd19, 1'b0, 6'd40});
    gen_offsets(16'hA5A5);
    run_prog(2, 16'hA5A5, -1, 1'b0, 2'd0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
